// File: rtl/tx_arbiter.sv
`default_nettype none
// ==================================================================
// tx_arbiter : packet round-robin arbiter and config sequencer that
//              shares one UART transmitter and TX FIFO.  Rev 1.0
// ==================================================================
module tx_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int ID_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [N_CLIENTS-1:0]   client_valid_i,
  input  logic [8*N_CLIENTS-1:0] client_data_i,
  input  logic [N_CLIENTS-1:0]   client_last_i,
  output logic [N_CLIENTS-1:0]   client_ready_o,
  output logic [N_CLIENTS-1:0]   grant_o,
  output logic [ID_W-1:0]        grant_id_o,
  input  logic                   cfg_req_i,
  output logic                   cfg_busy_o,
  output logic                   cfg_done_o,
  input  logic                   tx_fifo_full_i,
  input  logic                   tx_fifo_empty_i,
  input  logic                   tx_idle_i,
  input  logic                   req_done_i,
  output logic [7:0]             data_tx_o,
  output logic                   tx_fifo_write_o,
  output logic                   config_req_mst_o
);

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GRANT     = 2'd1,
    ARB_CFG_DRAIN = 2'd2,
    ARB_CFG_REQ   = 2'd3
  } arb_state_t;

  arb_state_t             r_state;
  arb_state_t             w_next;
  logic [ID_W-1:0]        r_rr_ptr;
  logic                   r_cfg_pend;
  logic [N_CLIENTS-1:0]   r_grant;
  logic [ID_W-1:0]        r_grant_id;
  logic                   r_cfg_req_mst;
  logic                   r_cfg_done;

  logic                   w_found;
  logic [ID_W-1:0]        w_pick;
  logic [N_CLIENTS-1:0]   w_pick_oh;
  logic [N_CLIENTS-1:0]   w_ready;
  logic [7:0]             w_gdata;
  logic [7:0]             w_data;
  logic                   w_gvalid;
  logic                   w_glast;
  logic                   w_xfer;
  logic                   w_end;
  logic                   w_load;
  logic                   w_cfg_start;
  logic                   w_cfg_exit;
  logic                   w_in_cfg;
  logic [ID_W-1:0]        w_ptr_nxt;

  // Pick the valid client with the smallest wrapped distance from rr_ptr.
  always_comb begin
    int w_best;
    int w_dist;
    int w_pick_int;
    w_best     = N_CLIENTS;
    w_dist     = 0;
    w_pick_int = 0;
    for (int j = 0; j < N_CLIENTS; j++) begin
      w_dist = j - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + N_CLIENTS;
      if (client_valid_i[j] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_pick_int = j;
      end
    end
    w_found = (w_best < N_CLIENTS);
    w_pick  = w_pick_int[ID_W-1:0];
    for (int j = 0; j < N_CLIENTS; j++) begin
      w_pick_oh[j] = (j == w_pick_int);
    end
  end

  always_comb begin
    w_gdata = 8'h00;
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_gdata = w_gdata | (client_data_i[8*i +: 8] & {8{r_grant[i]}});
    end
    w_gvalid  = |(client_valid_i & r_grant);
    w_glast   = |(client_last_i & r_grant);
    w_ptr_nxt = (int'(r_grant_id) == N_CLIENTS - 1) ? '0 : r_grant_id + ID_W'(1);
  end

  always_comb begin
    w_next      = r_state;
    w_ready     = '0;
    w_xfer      = 1'b0;
    w_data      = 8'h00;
    w_end       = 1'b0;
    w_load      = 1'b0;
    w_cfg_start = 1'b0;
    w_cfg_exit  = 1'b0;
    w_in_cfg    = (r_state == ARB_CFG_DRAIN) || (r_state == ARB_CFG_REQ);
    case (r_state)
      ARB_IDLE: begin
        if (r_cfg_pend || cfg_req_i) begin
          w_next = ARB_CFG_DRAIN;
        end else if (enable_i && w_found) begin
          w_next = ARB_GRANT;
          w_load = 1'b1;
        end
      end
      ARB_GRANT: begin
        w_ready = r_grant & {N_CLIENTS{enable_i & ~tx_fifo_full_i}};
        w_xfer  = w_gvalid & enable_i & ~tx_fifo_full_i;
        if (w_xfer) begin
          w_data = w_gdata;
          if (w_glast) begin
            w_end  = 1'b1;
            w_next = ARB_IDLE;
          end
        end
      end
      ARB_CFG_DRAIN: begin
        if (tx_fifo_empty_i && tx_idle_i) begin
          w_next      = ARB_CFG_REQ;
          w_cfg_start = 1'b1;
        end
      end
      ARB_CFG_REQ: begin
        // req_done only counts once the request is actually visible.
        if (r_cfg_req_mst && req_done_i) begin
          w_cfg_exit = 1'b1;
          w_next     = ARB_IDLE;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= ARB_IDLE;
      r_rr_ptr      <= '0;
      r_cfg_pend    <= 1'b0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_cfg_req_mst <= 1'b0;
      r_cfg_done    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cfg_done <= w_cfg_exit;
      if (w_cfg_exit) begin
        r_cfg_pend <= 1'b0;
      end else if (cfg_req_i && !w_in_cfg) begin
        r_cfg_pend <= 1'b1;
      end
      if (w_load) begin
        r_grant    <= w_pick_oh;
        r_grant_id <= w_pick;
      end else if (w_end) begin
        r_grant  <= '0;
        r_rr_ptr <= w_ptr_nxt;
      end
      if (w_cfg_start) begin
        r_cfg_req_mst <= 1'b1;
      end else if (w_cfg_exit) begin
        r_cfg_req_mst <= 1'b0;
      end
    end
  end

  assign client_ready_o   = w_ready;
  assign grant_o          = r_grant;
  assign grant_id_o       = r_grant_id;
  assign data_tx_o        = w_data;
  assign tx_fifo_write_o  = w_xfer;
  assign config_req_mst_o = r_cfg_req_mst;
  assign cfg_busy_o       = r_cfg_pend | w_in_cfg;
  assign cfg_done_o       = r_cfg_done;

endmodule
`default_nettype wire

// File: tb/tb_tx_arbiter.sv
`default_nettype none
// Bench for tx_arbiter: vector table, directed sequences and random traffic
// checked against a packet-level round-robin model.
module tb_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, full, empty, idle, cfg_req, req_done;
  logic [3:0]  valid, last;
  logic [31:0] data;

  logic [3:0] ready4, g4;
  logic [1:0] gid4;
  logic [7:0] d4;
  logic       wr4, mst4, busy4, done4;
  logic [2:0] ready3, g3;
  logic [1:0] gid3;
  logic [7:0] d3;
  logic       wr3, mst3, busy3, done3;

  always #5 clk = ~clk;

  tx_arbiter #(.N_CLIENTS(4)) u4 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en),
    .client_valid_i(valid), .client_data_i(data), .client_last_i(last),
    .client_ready_o(ready4), .grant_o(g4), .grant_id_o(gid4),
    .cfg_req_i(cfg_req), .cfg_busy_o(busy4), .cfg_done_o(done4),
    .tx_fifo_full_i(full), .tx_fifo_empty_i(empty), .tx_idle_i(idle),
    .req_done_i(req_done), .data_tx_o(d4), .tx_fifo_write_o(wr4),
    .config_req_mst_o(mst4));

  tx_arbiter #(.N_CLIENTS(3)) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(en),
    .client_valid_i(valid[2:0]), .client_data_i(data[23:0]), .client_last_i(last[2:0]),
    .client_ready_o(ready3), .grant_o(g3), .grant_id_o(gid3),
    .cfg_req_i(cfg_req), .cfg_busy_o(busy3), .cfg_done_o(done3),
    .tx_fifo_full_i(full), .tx_fifo_empty_i(empty), .tx_idle_i(idle),
    .req_done_i(req_done), .data_tx_o(d3), .tx_fifo_write_o(wr3),
    .config_req_mst_o(mst3));

  typedef struct {
    int         id;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [3:0] grant;
    logic [1:0] gid;
    logic [3:0] ready;
    logic       wr;
    logic [7:0] d;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  // Client byte sources: per-client byte list with a head pointer.
  logic [7:0] m_d [4][16];
  logic       m_l [4][16];
  int         m_n [4];
  int         m_h [4];
  bit         qmode;
  bit         sel3;
  wr_t        wlog[$];
  wr_t        exp_q[$];

  logic [3:0] s_grant, s_ready;
  logic [1:0] s_gid;
  logic [7:0] s_data;
  logic       s_wr, s_mst, s_busy, s_done;
  int         n_viol;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic drive_q();
    for (int c = 0; c < 4; c++) begin
      if (m_h[c] < m_n[c]) begin
        valid[c]      = 1'b1;
        data[8*c +: 8] = m_d[c][m_h[c]];
        last[c]       = m_l[c][m_h[c]];
      end else begin
        valid[c]      = 1'b0;
        data[8*c +: 8] = 8'h00;
        last[c]       = 1'b0;
      end
    end
  endtask

  task automatic add_pkt(input int c, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) begin
      m_d[c][m_n[c]] = base + 8'(b);
      m_l[c][m_n[c]] = (b == len - 1);
      m_n[c]++;
    end
  endtask

  // One clock: inputs already applied, sample at negedge, return at posedge+1.
  task automatic cyc();
    int xc;
    if (qmode) drive_q();
    @(negedge clk);
    s_grant = sel3 ? {1'b0, g3} : g4;
    s_ready = sel3 ? {1'b0, ready3} : ready4;
    s_gid   = sel3 ? gid3 : gid4;
    s_data  = sel3 ? d3 : d4;
    s_wr    = sel3 ? wr3 : wr4;
    s_mst   = sel3 ? mst3 : mst4;
    s_busy  = sel3 ? busy3 : busy4;
    s_done  = sel3 ? done3 : done4;
    xc = -1;
    if (s_wr) begin
      for (int c = 0; c < 4; c++) if (s_ready[c] && valid[c]) xc = c;
      wlog.push_back('{xc, s_data});
    end
    if (s_wr && full) n_viol++;
    if (!en && (s_ready != 4'b0000)) n_viol++;
    @(posedge clk);
    #1;
    if (qmode && xc >= 0) m_h[xc]++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      m_n[c] = 0;
      m_h[c] = 0;
    end
    valid = '0; last = '0; data = '0;
    en = 1'b1; full = 1'b0; empty = 1'b1; idle = 1'b1;
    cfg_req = 1'b0; req_done = 1'b0;
    wlog.delete();
    n_viol = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({g4, gid4, ready4, d4, wr4, mst4, busy4, done4}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: visit clients in round-robin order from the
  // pointer, each turn emitting one whole packet of that client.
  task automatic model(input int npk[4], input int plen[4][3]);
    int ptr, pk[4], pos[4], cc;
    bit any;
    ptr = 0;
    for (int c = 0; c < 4; c++) begin pk[c] = 0; pos[c] = 0; end
    exp_q.delete();
    forever begin
      any = 0;
      cc  = 0;
      for (int k = 3; k >= 0; k--) begin
        if (pk[(ptr + k) % 4] < npk[(ptr + k) % 4]) begin
          any = 1;
          cc  = (ptr + k) % 4;
        end
      end
      if (!any) break;
      for (int b = 0; b < plen[cc][pk[cc]]; b++) exp_q.push_back('{cc, m_d[cc][pos[cc] + b]});
      pos[cc] += plen[cc][pk[cc]];
      pk[cc]++;
      ptr = (cc + 1) % 4;
    end
  endtask

  vec_t tv[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt, got;
    int npk[4];
    int plen[4][3];

    tv[0]  = '{4'b1011, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 8'h00};
    tv[1]  = '{4'b1011, 4'b0000, 4'b0001, 2'd0, 4'b0001, 1'b1, 8'hC0};
    tv[2]  = '{4'b1011, 4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b1, 8'hC0};
    tv[3]  = '{4'b1011, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 8'h00};
    tv[4]  = '{4'b1011, 4'b0000, 4'b0010, 2'd1, 4'b0010, 1'b1, 8'hC1};
    tv[5]  = '{4'b1011, 4'b0010, 4'b0010, 2'd1, 4'b0010, 1'b1, 8'hC1};
    tv[6]  = '{4'b1011, 4'b0000, 4'b0000, 2'd1, 4'b0000, 1'b0, 8'h00};
    tv[7]  = '{4'b1011, 4'b0000, 4'b1000, 2'd3, 4'b1000, 1'b1, 8'hC3};
    tv[8]  = '{4'b1011, 4'b1000, 4'b1000, 2'd3, 4'b1000, 1'b1, 8'hC3};
    tv[9]  = '{4'b1011, 4'b0000, 4'b0000, 2'd3, 4'b0000, 1'b0, 8'h00};
    tv[10] = '{4'b1011, 4'b0000, 4'b0001, 2'd0, 4'b0001, 1'b1, 8'hC0};
    tv[11] = '{4'b1011, 4'b0001, 4'b0001, 2'd0, 4'b0001, 1'b1, 8'hC0};
    tv[12] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 4'b0000, 1'b0, 8'h00};

    qmode = 0; sel3 = 0;
    do_reset();

    // Round robin 0,1,3 with 2-byte packets, vector table.
    data = 32'hC3C2C1C0;
    for (int k = 0; k < 13; k++) begin
      valid = tv[k].valid;
      last  = tv[k].last;
      cyc();
      chk($sformatf("rr_grant[%0d]", k), 32'(s_grant), 32'(tv[k].grant));
      chk($sformatf("rr_gid[%0d]", k),   32'(s_gid),   32'(tv[k].gid));
      chk($sformatf("rr_ready[%0d]", k), 32'(s_ready), 32'(tv[k].ready));
      chk($sformatf("rr_wr[%0d]", k),    32'(s_wr),    32'(tv[k].wr));
      chk($sformatf("rr_data[%0d]", k),  32'(s_data),  32'(tv[k].d));
    end

    // FIFO-full backpressure mid-packet.
    do_reset();
    qmode = 1;
    add_pkt(1, 1, 8'h11);
    m_l[1][0] = 1'b0;
    m_d[1][1] = 8'hA5; m_l[1][1] = 1'b0;
    m_d[1][2] = 8'h3C; m_l[1][2] = 1'b1;
    m_n[1] = 3;
    cyc(); cyc();
    full = 1'b1;
    cnt = 0;
    repeat (5) begin
      cyc();
      if (s_ready == 4'b0000 && !s_wr && s_grant == 4'b0010) cnt++;
    end
    chk("bp_stalled_cycles", 32'(cnt), 32'd5);
    full = 1'b0;
    for (int k = 0; k < 10 && wlog.size() < 3; k++) cyc();
    cyc(); cyc();
    chk("bp_write_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("bp_byte0", 32'(wlog[0].d), 32'h11);
      chk("bp_byte1", 32'(wlog[1].d), 32'hA5);
      chk("bp_byte2", 32'(wlog[2].d), 32'h3C);
      chk("bp_id", 32'(wlog[2].id), 32'd1);
    end

    // Configuration request during client 2's packet.
    do_reset();
    qmode = 1;
    empty = 1'b0; idle = 1'b0;
    add_pkt(2, 4, 8'h20);
    add_pkt(3, 2, 8'h30);
    cyc(); cyc();
    cfg_req = 1'b1;
    cyc();
    cfg_req = 1'b0;
    for (int k = 0; k < 20 && wlog.size() < 4; k++) cyc();
    chk("cfgp_busy_during_pkt", 32'(s_busy), 32'd1);
    chk("cfgp_pkt_len", 32'(wlog.size()), 32'd4);
    cnt = 0;
    for (int k = 0; k < wlog.size(); k++) if (wlog[k].id == 2 && wlog[k].d == 8'h20 + 8'(k)) cnt++;
    chk("cfgp_pkt_bytes", 32'(cnt), 32'd4);
    idle = 1'b1;
    cnt = 0;
    repeat (4) begin
      cyc();
      if (s_mst || s_grant != 4'b0000 || s_ready != 4'b0000 || !s_busy) cnt++;
    end
    chk("cfgp_drain_hold", 32'(cnt), 32'd0);
    empty = 1'b1;
    got = 0;
    for (int k = 0; k < 5 && !got; k++) begin
      cyc();
      if (s_mst) got = 1;
    end
    chk("cfgp_mst_rise", 32'(got), 32'd1);
    cnt = 0;
    repeat (20) begin
      cyc();
      if (s_mst && !s_done) cnt++;
    end
    chk("cfgp_mst_held", 32'(cnt), 32'd20);
    req_done = 1'b1;
    cyc();
    req_done = 1'b0;
    cyc();
    chk("cfgp_done_pulse", 32'({s_done, s_busy, s_mst}), 32'b100);
    cyc();
    chk("cfgp_done_low", 32'(s_done), 32'd0);
    chk("cfgp_next_grant", 32'({s_grant, s_gid}), 32'({4'b1000, 2'd3}));
    for (int k = 0; k < 10 && wlog.size() < 6; k++) cyc();
    chk("cfgp_c3_bytes", 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6) chk("cfgp_c3_data", 32'({wlog[4].d, wlog[5].d}), 32'h3031);

    // Configuration and client 0 arrive together in ARB_IDLE.
    do_reset();
    qmode = 1;
    empty = 1'b0; idle = 1'b0;
    add_pkt(0, 2, 8'h40);
    cfg_req = 1'b1;
    cyc();
    cfg_req = 1'b0;
    cnt = 0;
    repeat (3) begin
      cyc();
      if (s_grant != 4'b0000 || s_ready != 4'b0000 || !s_busy) cnt++;
    end
    chk("sim_cfg_first", 32'(cnt), 32'd0);
    empty = 1'b1; idle = 1'b1; req_done = 1'b1;
    cyc();
    chk("sim_mst_before_req", 32'(s_mst), 32'd0);
    req_done = 1'b0;
    cyc();
    chk("sim_early_done_ignored", 32'(s_mst), 32'd1);
    cfg_req = 1'b1;
    cyc();
    cfg_req = 1'b0;
    cnt = 0;
    repeat (3) begin cyc(); if (s_mst) cnt++; end
    chk("sim_mst_held", 32'(cnt), 32'd3);
    req_done = 1'b1;
    cyc();
    req_done = 1'b0;
    cyc();
    chk("sim_done", 32'({s_done, s_grant, s_mst}), 32'({1'b1, 4'b0000, 1'b0}));
    cyc();
    chk("sim_grant_after_done", 32'({s_grant, s_mst}), 32'({4'b0001, 1'b0}));
    cnt = 0;
    repeat (8) begin cyc(); if (s_mst || s_done || s_busy) cnt++; end
    chk("sim_no_second_cfg", 32'(cnt), 32'd0);
    chk("sim_c0_bytes", 32'(wlog.size()), 32'd2);

    // Wrap with N_CLIENTS=3, then asynchronous reset mid-packet.
    do_reset();
    qmode = 1; sel3 = 1;
    add_pkt(2, 2, 8'h50);
    for (int k = 0; k < 10 && wlog.size() < 2; k++) cyc();
    chk("wrap_c2_pkt", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) chk("wrap_c2_id", 32'(wlog[1].id), 32'd2);
    add_pkt(0, 2, 8'h60);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin cyc(); if (s_grant != 4'b0000) got = 1; end
    chk("wrap_grant0", 32'({s_grant, s_gid}), 32'({4'b0001, 2'd0}));
    for (int k = 0; k < 10 && wlog.size() < 4; k++) cyc();
    add_pkt(0, 1, 8'h70);
    add_pkt(1, 1, 8'h71);
    add_pkt(2, 1, 8'h72);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin cyc(); if (s_grant != 4'b0000) got = 1; end
    chk("wrap_ptr_after_c0", 32'({s_grant, s_gid}), 32'({4'b0010, 2'd1}));
    for (int k = 0; k < 20 && wlog.size() < 7; k++) cyc();
    chk("wrap_single_cnt", 32'(wlog.size()), 32'd7);
    if (wlog.size() == 7) chk("wrap_single_order", 32'({wlog[4].d, wlog[5].d, wlog[6].d}), 32'h717270);
    add_pkt(1, 3, 8'h80);
    for (int k = 0; k < 10 && wlog.size() < 8; k++) cyc();
    chk("rst_mid_pkt_started", 32'({s_wr, s_grant}), 32'({1'b1, 4'b0010}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_u3", 32'({g3, gid3, ready3, d3, wr3, mst3, busy3, done3}), 32'd0);
    chk("rst_async_u4", 32'({g4, gid4, ready4, d4, wr4, mst4, busy4, done4}), 32'd0);
    sel3 = 0;

    // Random packets and random stalls against the round-robin model.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < 4; c++) begin
        npk[c] = $urandom_range(0, 3);
        for (int k = 0; k < 3; k++) plen[c][k] = 0;
        for (int k = 0; k < npk[c]; k++) begin
          plen[c][k] = $urandom_range(1, 4);
          for (int b = 0; b < plen[c][k]; b++) begin
            m_d[c][m_n[c]] = 8'($urandom);
            m_l[c][m_n[c]] = (b == plen[c][k] - 1);
            m_n[c]++;
          end
        end
      end
      model(npk, plen);
      qmode = 1;
      for (int k = 0; k < 2000 && wlog.size() < exp_q.size(); k++) begin
        full = ($urandom_range(0, 9) < 3);
        en   = ($urandom_range(0, 9) < 8);
        cyc();
      end
      full = 1'b0; en = 1'b1;
      cyc(); cyc();
      chk($sformatf("rnd%0d_count", it), 32'(wlog.size()), 32'(exp_q.size()));
      chk($sformatf("rnd%0d_protocol", it), 32'(n_viol), 32'd0);
      cnt = 0;
      for (int k = 0; k < exp_q.size() && k < wlog.size(); k++) begin
        if (wlog[k].id != exp_q[k].id || wlog[k].d !== exp_q[k].d) begin
          if (cnt == 0)
            $display("FAIL rnd%0d_stream[%0d]: got id %0d byte %0h expected id %0d byte %0h",
                     it, k, wlog[k].id, wlog[k].d, exp_q[k].id, exp_q[k].d);
          cnt++;
        end
      end
      n_chk++;
      if (cnt != 0) n_fail++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tx_arbiter.md
# tx_arbiter

Packet-level round-robin arbiter and request sequencer in front of the UART transmitter. It shares one transmitter and its TX FIFO between `N_CLIENTS` byte-stream requesters. Each client holds the grant until its packet completes. The block also sequences master configuration requests: it drains the FIFO, waits for the transmitter to go idle, then holds `config_req_mst` until the transmitter reports `req_done`.

## Interface
Parameters:
- `N_CLIENTS`, default 4: number of requesters; legal range is 1 to 16.
- `ID_W`, default `$clog2(N_CLIENTS)` with a minimum of 1: width of the grant index.

Ports:
- `clk_i`  in  1: system clock. All logic is on the rising edge.
- `rst_n_i`  in  1: reset, asynchronous and active-low.
- `enable_i`  in  1: when low, no new grants are issued and all `client_ready_o` bits are 0.
- `client_valid_i`  in  N_CLIENTS: client i has a byte available.
- `client_data_i`  in  8*N_CLIENTS: byte of client i, carried on bits [8i+7:8i].
- `client_last_i`  in  N_CLIENTS: the current byte of client i ends its packet.
- `client_ready_o`  out  N_CLIENTS: the byte of client i is accepted this cycle.
- `grant_o`  out  N_CLIENTS: one-hot owner of the transmitter, registered.
- `grant_id_o`  out  ID_W: binary index of the owner, registered.
- `cfg_req_i`  in  1: pulse or level that requests a configuration handshake.
- `cfg_busy_o`  out  1: a configuration request is pending or in progress.
- `cfg_done_o`  out  1: one-cycle pulse when the configuration handshake completes.
- `tx_fifo_full_i`, `tx_fifo_empty_i`, `tx_idle_i`, `req_done_i`  in  1 each: status inputs from the transmitter.
- `data_tx_o`  out  8: byte to the TX FIFO.
- `tx_fifo_write_o`  out  1: TX FIFO write strobe.
- `config_req_mst_o`  out  1: configuration request to the transmitter.

## Operation
- FSM states: `ARB_IDLE`, `ARB_GRANT`, `ARB_CFG_DRAIN`, `ARB_CFG_REQ`.
- `cfg_pend` flag:
  - Set by `cfg_req_i` in any state.
  - Cleared when `ARB_CFG_REQ` exits.
  - A `cfg_req_i` that arrives while `cfg_pend` or `ARB_CFG_*` is active is absorbed; there is no second request.
  - `cfg_busy_o` = `cfg_pend` or state in `ARB_CFG_*`.
- `ARB_IDLE`:
  - If `cfg_pend` or `cfg_req_i` is set, go to `ARB_CFG_DRAIN`. Configuration wins over a client valid in the same cycle.
  - Otherwise, if `enable_i` is high and any `client_valid_i` is set, grant the first valid client searching from `rr_ptr` upward with wrap-around. Load `grant_o`/`grant_id_o` and go to `ARB_GRANT`.
- `ARB_GRANT`:
  - `client_ready_o[g]` = `enable_i` and not `tx_fifo_full_i`; all other ready bits are 0.
  - A beat transfers when `valid[g]` and `ready[g]` are both high. On a transfer, `tx_fifo_write_o` = 1 and `data_tx_o` = `client_data_i[g]`.
  - When no transfer occurs, `data_tx_o` = 0.
  - A transfer with `client_last_i[g]` set ends the packet: `rr_ptr` ← (g+1) mod N_CLIENTS, `grant_o` ← 0, next state `ARB_IDLE`.
  - Configuration never preempts a packet in progress.
- `ARB_CFG_DRAIN`:
  - All ready bits are 0.
  - When `tx_fifo_empty_i` and `tx_idle_i` are both high, go to `ARB_CFG_REQ`.
- `ARB_CFG_REQ`:
  - `config_req_mst_o` = 1, registered and held until `req_done_i` is seen.
  - On `req_done_i`: `config_req_mst_o` ← 0, `cfg_done_o` pulses for 1 cycle, `cfg_pend` clears, next state `ARB_IDLE`.
- `rr_ptr` is ID_W wide. It must wrap N_CLIENTS−1 → 0 for non-power-of-two N_CLIENTS and never hold a value ≥ N_CLIENTS.

## Timing
- Reset values: state `ARB_IDLE`, `rr_ptr` 0, `cfg_pend` 0. All outputs are 0: `grant_o`, `grant_id_o`, `client_ready_o`, `data_tx_o`, `tx_fifo_write_o`, `config_req_mst_o`, `cfg_busy_o`, `cfg_done_o`.
- Reset mid-packet or mid-configuration aborts immediately. Bytes already written to the FIFO stay written.
- Grant latency: valid seen in `ARB_IDLE` at cycle t, `grant_o` set at t+1, first byte accepted at t+1 at the earliest.
- Forwarding is zero-latency combinational: `tx_fifo_write_o` and `data_tx_o` depend on same-cycle `valid[g]` and `tx_fifo_full_i`.
- Sustained throughput is 1 byte/cycle while the FIFO is not full.
- Packet-to-packet gap is 1 idle cycle in `ARB_IDLE`.
- `tx_fifo_full_i` high stalls the transfer with no data loss. The client must hold its data and last flag stable until ready.
- `enable_i` low in `ARB_GRANT` keeps the grant and stalls transfers.
- `req_done_i` asserted in the same cycle that `ARB_CFG_REQ` is entered is ignored. `req_done_i` is only sampled while `config_req_mst_o` is 1.
- A single-byte packet (valid and last together) is legal: 1 cycle in `ARB_GRANT`.

## Test plan
- **Round robin:** `N_CLIENTS`=4, clients 0, 1 and 3 each continuously valid with 2-byte packets. Required FIFO write order: 0,0,1,1,3,3,0,0. `grant_id_o` sequence 0→1→3→0, with a 1-cycle `ARB_IDLE` gap between packets.
- **FIFO-full backpressure:** `tx_fifo_full_i` high for 5 cycles mid-packet. Required: `client_ready_o`=0 and `tx_fifo_write_o`=0 for those 5 cycles. Bytes 0xA5, 0x3C are written once each, in order, after the full condition clears.
- **Configuration during a packet:** `cfg_req_i` pulsed while client 2 is mid-packet. Required:
  - the packet completes;
  - the block enters `ARB_CFG_DRAIN`;
  - `config_req_mst_o` rises only after `tx_fifo_empty_i`=`tx_idle_i`=1;
  - `req_done_i` after 20 cycles gives a 1-cycle `cfg_done_o` and `cfg_busy_o` falling;
  - the next grant goes to client 3.
- **Simultaneous events:** `cfg_req_i` and `client_valid_i`[0] both rise while in `ARB_IDLE`. Required: configuration is served first and client 0 is granted only after `cfg_done_o`. A second `cfg_req_i` during `ARB_CFG_REQ` produces no second `config_req_mst_o`.
- **Wrap and reset:** `N_CLIENTS`=3, only client 2 valid, then only client 0. Required: `rr_ptr` goes 0→0→1 (wrapping from 2 to 0 after client 2's packet). Asserting `rst_n_i` low mid-packet asynchronously clears all outputs to 0 within the same cycle.
